// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions the raw PS/2 clock/data pair,
// deserialises 11-bit frames and turns the byte stream into the 11-bit
// ps2_key event word (toggle, make/break, extended, scancode).
module ps2_keyboard_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [1:0]    r_clkSync;
  logic [1:0]    r_dataSync;
  logic [FW-1:0] r_filtCnt;
  logic          r_fclk;
  logic          r_fclkPrev;

  state_t        r_state;
  state_t        w_stateNext;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_toCnt;

  logic          r_frameErr;
  logic          r_byteValid;
  logic [7:0]    r_byte;

  logic [10:0]   r_key;
  logic          r_ext;
  logic          r_brk;
  logic [2:0]    r_skip;

  logic          w_fall;
  logic          w_data;
  logic          w_timeout;
  logic          w_err;
  logic          w_accept;

  // Two-flop synchronisers; idle-high so reset looks like a quiet bus
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
    end
  end

  // Glitch filter: the filtered clock only follows after FILTER_LEN
  // consecutive samples disagreeing with its current level
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_filtCnt  <= '0;
      r_fclk     <= 1'b1;
      r_fclkPrev <= 1'b1;
    end else begin
      r_fclkPrev <= r_fclk;
      if (r_clkSync[1] == r_fclk) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FW'(FILTER_LEN - 1)) begin
        r_fclk    <= r_clkSync[1];
        r_filtCnt <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + 1'b1;
      end
    end
  end

  assign w_fall    = r_fclkPrev & ~r_fclk;
  assign w_data    = r_dataSync[1];
  assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_toCnt == TW'(TIMEOUT));

  // Frame state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Frame next-state logic plus accept/error decisions for the current fall
  always_comb begin
    w_stateNext = r_state;
    w_err       = 1'b0;
    w_accept    = 1'b0;
    if (w_timeout) begin
      w_stateNext = ST_IDLE;
      w_err       = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_data) begin
            w_stateNext = ST_DATA;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_DATA: begin
          if (r_bitCnt == 3'd7) begin
            w_stateNext = ST_PARITY;
          end
        end
        ST_PARITY: begin
          w_stateNext = ST_STOP;
        end
        ST_STOP: begin
          w_stateNext = ST_IDLE;
          if (w_data && ((^r_shift) ^ r_parity)) begin
            w_accept = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
        end
      endcase
    end
  end

  // Frame datapath: bit counter, shift register, parity and inactivity timer
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_toCnt  <= '0;
    end else begin
      if (r_state == ST_IDLE || w_timeout || w_fall) begin
        r_toCnt <= '0;
      end else begin
        r_toCnt <= r_toCnt + 1'b1;
      end
      if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            r_bitCnt <= '0;
            r_shift  <= '0;
          end
          ST_DATA: begin
            r_shift[r_bitCnt] <= w_data;
            r_bitCnt          <= r_bitCnt + 1'b1;
          end
          ST_PARITY: begin
            r_parity <= w_data;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Registered error pulse and accepted-byte handoff to the interpreter
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_frameErr  <= 1'b0;
      r_byteValid <= 1'b0;
      r_byte      <= '0;
    end else begin
      r_frameErr  <= w_err;
      r_byteValid <= w_accept;
      if (w_accept) begin
        r_byte <= r_shift;
      end
    end
  end

  // Byte interpreter: prefixes, status bytes, Pause skipping, event output
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_key  <= '0;
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_skip <= '0;
    end else if (r_byteValid) begin
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 1'b1;
      end else begin
        case (r_byte)
          8'hE0: r_ext  <= 1'b1;
          8'hF0: r_brk  <= 1'b1;
          8'hE1: r_skip <= 3'd7;
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
          end
          default: begin
            r_key <= {~r_key[10], ~r_brk, r_ext, r_byte};
            r_ext <= 1'b0;
            r_brk <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ps2_key   = r_key;
  assign frame_err = r_frameErr;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: a table of byte sequences with
// expected event words, then hand-written error/timeout/glitch/reset cases.
module tb_ps2_keyboard_rx;

  localparam int FL = 4;
  localparam int TO = 300;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  int total    = 0;
  int bad      = 0;
  int errCount = 0;
  int e0;

  typedef struct {
    string       name;
    int          n;
    logic [63:0] bytes;
    logic [10:0] expKey;
  } vec_t;

  vec_t vecs [10];

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );

  // System clock
  always #5 clk_sys = ~clk_sys;

  // Count frame error pulses, sampled away from the active edge
  always @(negedge clk_sys) begin
    if (!reset && frame_err) errCount++;
  end

  // One comparison: prints a FAIL line on mismatch
  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One PS/2 bit: data set while high, clock low, clock high, optional glitch
  task automatic sendBit(input logic b, input bit glitch);
    ps2_data = b;
    repeat (10) @(posedge clk_sys);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk_sys);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk_sys);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FL - 1) @(posedge clk_sys);
      ps2_clk = 1'b1;
      repeat (10) @(posedge clk_sys);
    end
  endtask

  // A full frame with optional parity corruption, stop bit value and glitches
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input logic stopBit,
                               input bit glitch);
    logic par;
    par = (~^b) ^ badPar;
    sendBit(1'b0, glitch);
    for (int i = 0; i < 8; i++) sendBit(b[i], glitch);
    sendBit(par, glitch);
    sendBit(stopBit, glitch);
    repeat (5) @(posedge clk_sys);
  endtask

  task automatic sendClean(input logic [7:0] b);
    applyStimulus(b, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    vecs[0] = '{"make_1C",       1, 64'h1C00_0000_0000_0000, 11'h61C};
    vecs[1] = '{"break_1C",      2, 64'hF01C_0000_0000_0000, 11'h01C};
    vecs[2] = '{"ext_make_75",   2, 64'hE075_0000_0000_0000, 11'h775};
    vecs[3] = '{"ext_break_75",  3, 64'hE0F0_7500_0000_0000, 11'h175};
    vecs[4] = '{"plain_12",      1, 64'h1200_0000_0000_0000, 11'h612};
    vecs[5] = '{"status_AA_FA",  2, 64'hAAFA_0000_0000_0000, 11'h612};
    vecs[6] = '{"after_stat_2B", 1, 64'h2B00_0000_0000_0000, 11'h22B};
    vecs[7] = '{"pause_seq",     8, 64'hE114_77E1_F014_F077, 11'h22B};
    vecs[8] = '{"after_pause",   1, 64'h1C00_0000_0000_0000, 11'h61C};
    vecs[9] = '{"E0_AA_clears",  3, 64'hE0AA_1C00_0000_0000, 11'h21C};

    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("reset_key", int'(ps2_key), 0);
    checkOutput("reset_err", int'(frame_err), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk_sys);

    for (int v = 0; v < 10; v++) begin
      e0 = errCount;
      for (int j = 0; j < vecs[v].n; j++) begin
        sendClean(vecs[v].bytes[63 - 8*j -: 8]);
      end
      @(negedge clk_sys);
      checkOutput({vecs[v].name, "_key"}, int'(ps2_key), int'(vecs[v].expKey));
      checkOutput({vecs[v].name, "_err"}, errCount - e0, 0);
    end

    // Parity error: byte discarded, one error pulse
    e0 = errCount;
    applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0);
    @(negedge clk_sys);
    checkOutput("parity_err", errCount - e0, 1);
    checkOutput("parity_key", int'(ps2_key), 'h21C);

    // Stop bit 0: byte discarded, one error pulse
    e0 = errCount;
    applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
    @(negedge clk_sys);
    checkOutput("stop_err", errCount - e0, 1);
    checkOutput("stop_key", int'(ps2_key), 'h21C);

    // Start bit 1: error, FSM stays idle so the next frame is clean
    e0 = errCount;
    sendBit(1'b1, 1'b0);
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("start_err", errCount - e0, 1);
    sendClean(8'h16);
    @(negedge clk_sys);
    checkOutput("after_start_key", int'(ps2_key), 'h616);

    // Extended prefix survives an intervening frame error
    e0 = errCount;
    sendClean(8'hE0);
    applyStimulus(8'h33, 1'b1, 1'b1, 1'b0);
    sendClean(8'h75);
    @(negedge clk_sys);
    checkOutput("persist_err", errCount - e0, 1);
    checkOutput("persist_key", int'(ps2_key), 'h375);

    // Timeout: four bits then silence
    e0 = errCount;
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    repeat (TO + 100) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("timeout_err", errCount - e0, 1);
    checkOutput("timeout_key", int'(ps2_key), 'h375);
    sendClean(8'h16);
    @(negedge clk_sys);
    checkOutput("after_timeout_key", int'(ps2_key), 'h616);

    // Short low glitches on ps2_clk between every bit
    e0 = errCount;
    applyStimulus(8'h24, 1'b0, 1'b1, 1'b1);
    @(negedge clk_sys);
    checkOutput("glitch_key", int'(ps2_key), 'h224);
    checkOutput("glitch_err", errCount - e0, 0);

    // Reset in the middle of a frame
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b0);
    sendBit(1'b1, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("midreset_key", int'(ps2_key), 0);
    checkOutput("midreset_err", int'(frame_err), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk_sys);
    e0 = errCount;
    sendClean(8'h1E);
    @(negedge clk_sys);
    checkOutput("after_reset_key", int'(ps2_key), 'h61E);
    checkOutput("after_reset_err", errCount - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
